// File: rtl/aes_cipher_share_collector.sv
// aes_cipher_share_collector
//   Assembles eight 16-bit ciphertext beats per share from a masked AES core
//   into two separate 128-bit share registers. It presents them with a
//   valid/ready handshake and flags beats that arrive while a block is
//   still held.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous reset, active-high
//   cipher0     share-0 beat (16 bits)
//   cipher1     share-1 beat (16 bits)
//   done        beat valid strobe
//   out_ready   sink ready
//   out_share0  assembled share 0 (128 bits)
//   out_share1  assembled share 1 (128 bits)
//   out_valid   assembled block available
//   collecting  high while a block is partially assembled
//   overflow    sticky flag for beats dropped in HOLD; cleared only by reset
//   out_cipher  (only with AES_UNMASKED_OUT_EN) registered out_share0 ^ out_share1
//
// Configuration macro: AES_UNMASKED_OUT_EN adds the unmasked out_cipher output.

module aes_cipher_share_collector (
  input  logic         clk,
  input  logic         rst,
  input  logic [15:0]  cipher0,
  input  logic [15:0]  cipher1,
  input  logic         done,
  input  logic         out_ready,
  output logic [127:0] out_share0,
  output logic [127:0] out_share1,
  output logic         out_valid,
  output logic         collecting,
  output logic         overflow
`ifdef AES_UNMASKED_OUT_EN
  ,
  output logic [127:0] out_cipher
`endif
);

  localparam int unsigned BEAT_W    = 16;
  localparam int unsigned NUM_BEATS = 8;
  localparam int unsigned BLOCK_W   = BEAT_W * NUM_BEATS;
  localparam int unsigned CNT_W     = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               capture;
  logic [CNT_W-1:0]   beat_idx;
  logic [BLOCK_W-1:0] sh0_nxt;
  logic [BLOCK_W-1:0] sh1_nxt;

  // A beat is taken unless a block is held and the sink is not accepting it.
  // Outside COLLECT, a captured beat is always beat 0 of a new block.
  always_comb begin
    capture  = done && ((state != HOLD) || out_ready);
    beat_idx = (state == COLLECT) ? cnt : '0;
    sh0_nxt  = out_share0;
    sh1_nxt  = out_share1;
    for (int i = 0; i < int'(NUM_BEATS); i++) begin
      if (capture && (beat_idx == CNT_W'(i))) begin
        sh0_nxt[(int'(NUM_BEATS) - 1 - i) * int'(BEAT_W) +: BEAT_W] = cipher0;
        sh1_nxt[(int'(NUM_BEATS) - 1 - i) * int'(BEAT_W) +: BEAT_W] = cipher1;
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      out_share0 <= '0;
      out_share1 <= '0;
      out_valid  <= 1'b0;
      collecting <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      out_share0 <= sh0_nxt;
      out_share1 <= sh1_nxt;
      case (state)
        IDLE: begin
          if (done) begin
            cnt        <= CNT_W'(1);
            state      <= COLLECT;
            collecting <= 1'b1;
          end
        end
        COLLECT: begin
          if (done) begin
            if (cnt == CNT_W'(NUM_BEATS - 1)) begin
              cnt        <= '0;
              state      <= HOLD;
              out_valid  <= 1'b1;
              collecting <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (done) begin
              // Back-to-back: this beat is beat 0 of the next block.
              cnt        <= CNT_W'(1);
              state      <= COLLECT;
              collecting <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (done) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state      <= IDLE;
          cnt        <= '0;
          out_valid  <= 1'b0;
          collecting <= 1'b0;
        end
      endcase
    end
  end

`ifdef AES_UNMASKED_OUT_EN
  // Unmasked view tracks the share registers cycle for cycle.
  always_ff @(posedge clk) begin
    if (rst) out_cipher <= '0;
    else     out_cipher <= sh0_nxt ^ sh1_nxt;
  end
`endif

endmodule

// File: tb/tb_aes_cipher_share_collector.sv
// Directed self-checking bench for aes_cipher_share_collector.
module tb_aes_cipher_share_collector;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  cipher0;
  logic [15:0]  cipher1;
  logic         done;
  logic         out_ready;
  logic [127:0] out_share0;
  logic [127:0] out_share1;
  logic         out_valid;
  logic         collecting;
  logic         overflow;
`ifdef AES_UNMASKED_OUT_EN
  logic [127:0] out_cipher;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [127:0] C_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] MASK   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C_B    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_D    = 128'hdeadbeefcafef00d0badc0de12345678;

  aes_cipher_share_collector dut (
    .clk        (clk),
    .rst        (rst),
    .cipher0    (cipher0),
    .cipher1    (cipher1),
    .done       (done),
    .out_ready  (out_ready),
    .out_share0 (out_share0),
    .out_share1 (out_share1),
    .out_valid  (out_valid),
    .collecting (collecting),
    .overflow   (overflow)
`ifdef AES_UNMASKED_OUT_EN
    ,
    .out_cipher (out_cipher)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] beat_of(input logic [127:0] blk, input int n);
    logic [127:0] sh;
    sh = blk >> (16 * (7 - n));
    return sh[15:0];
  endfunction

  // Send one block (share0 = c ^ m, share1 = m) with optional gaps of n%4 cycles.
  task automatic send_block(input logic [127:0] c, input logic [127:0] m, input bit gaps,
                            input string tag);
    for (int n = 0; n < 8; n++) begin
      if (gaps) begin
        for (int g = 0; g < (n % 4); g++) begin
          done = 1'b0;
          tick();
        end
      end
      cipher0 = beat_of(c ^ m, n);
      cipher1 = beat_of(m, n);
      done    = 1'b1;
      tick();
      done    = 1'b0;
      if (n == 0) check({tag, ":collecting_b0"}, 128'(collecting), 128'(1));
      if (n == 6) check({tag, ":valid_before_b7"}, 128'(out_valid), 128'(0));
    end
  endtask

  task automatic check_block(input logic [127:0] c, input logic [127:0] m, input string tag);
    check({tag, ":valid"}, 128'(out_valid), 128'(1));
    check({tag, ":share0"}, out_share0, c ^ m);
    check({tag, ":share1"}, out_share1, m);
    check({tag, ":xor"}, out_share0 ^ out_share1, c);
    check({tag, ":collecting"}, 128'(collecting), 128'(0));
`ifdef AES_UNMASKED_OUT_EN
    check({tag, ":out_cipher"}, out_cipher, c);
`endif
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    done      = 1'b0;
    tick();
    out_ready = 1'b0;
    check({tag, ":valid_after_hs"}, 128'(out_valid), 128'(0));
  endtask

  initial begin
    rst = 1'b1; cipher0 = '0; cipher1 = '0; done = 1'b0; out_ready = 1'b0;
    // Reset overrides a concurrent done.
    done = 1'b1;
    tick();
    tick();
    done = 1'b0;
    rst  = 1'b0;
    check("rst:valid", 128'(out_valid), 128'(0));
    check("rst:overflow", 128'(overflow), 128'(0));
    check("rst:collecting", 128'(collecting), 128'(0));
    check("rst:share0", out_share0, 128'(0));
    check("rst:share1", out_share1, 128'(0));

    // FIPS-197 C.1 ciphertext, share1 zero, back-to-back beats.
    send_block(C_FIPS, 128'(0), 1'b0, "fips");
    check_block(C_FIPS, 128'(0), "fips");
    handshake("fips");

    // Masked block with gaps.
    send_block(C_FIPS, MASK, 1'b1, "mask");
    check_block(C_FIPS, MASK, "mask");
    handshake("mask");

    // Held block, extra beat dropped, overflow sticky.
    send_block(C_B, MASK, 1'b0, "hold");
    tick();
    tick();
    check("hold:still_valid", 128'(out_valid), 128'(1));
    check("hold:ovf_before", 128'(overflow), 128'(0));
    cipher0 = 16'hffff; cipher1 = 16'haaaa; done = 1'b1;
    tick();
    done = 1'b0;
    check("hold:overflow", 128'(overflow), 128'(1));
    check_block(C_B, MASK, "hold_after_drop");
    handshake("hold");
    send_block(C_D, 128'(0), 1'b1, "post_ovf");
    check_block(C_D, 128'(0), "post_ovf");
    check("post_ovf:overflow_sticky", 128'(overflow), 128'(1));
    handshake("post_ovf");

    // Reset clears overflow.
    rst = 1'b1; tick(); rst = 1'b0;
    check("rst2:overflow", 128'(overflow), 128'(0));

    // 16 back-to-back beats with out_ready high: two blocks, no bubble.
    out_ready = 1'b1;
    for (int n = 0; n < 16; n++) begin
      cipher0 = (n < 8) ? beat_of(C_B, n) : beat_of(C_D ^ MASK, n - 8);
      cipher1 = (n < 8) ? 16'h0000 : beat_of(MASK, n - 8);
      done    = 1'b1;
      tick();
      if (n == 7) check_block(C_B, 128'(0), "b2b_a");
      if (n == 8) begin
        check("b2b:valid_after_b0", 128'(out_valid), 128'(0));
        check("b2b:collecting_b0", 128'(collecting), 128'(1));
      end
    end
    done = 1'b0;
    out_ready = 1'b0;
    check_block(C_D, MASK, "b2b_b");
    check("b2b:no_overflow", 128'(overflow), 128'(0));
    handshake("b2b");

    // Reset after 4 beats discards the partial block.
    for (int n = 0; n < 4; n++) begin
      cipher0 = beat_of(C_B, n); cipher1 = 16'h1234; done = 1'b1;
      tick();
    end
    done = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("rstmid:valid", 128'(out_valid), 128'(0));
    check("rstmid:collecting", 128'(collecting), 128'(0));
    check("rstmid:share0", out_share0, 128'(0));
    tick();
    check("rstmid:valid_later", 128'(out_valid), 128'(0));
    send_block(C_FIPS, MASK, 1'b0, "rstmid");
    check_block(C_FIPS, MASK, "rstmid");

    // Reset while holding discards the held block.
    rst = 1'b1; tick(); rst = 1'b0;
    check("rsthold:valid", 128'(out_valid), 128'(0));
    check("rsthold:share1", out_share1, 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/aes_cipher_share_collector.md
AES_CIPHER_SHARE_COLLECTOR -- requirements
Module: aes_cipher_share_collector

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-003 SHALL have port cipher0, input, 16 bits: ciphertext share 0 beat from the masked AES core.
REQ-004 SHALL have port cipher1, input, 16 bits: ciphertext share 1 beat from the masked AES core.
REQ-005 SHALL have port done, input, 1 bit: high marks a valid cipher0/cipher1 beat in that cycle.
REQ-006 SHALL have ports out_share0 and out_share1, outputs, 128 bits each: assembled ciphertext shares.
REQ-007 SHALL have port out_valid, output, 1 bit: assembled block available.
REQ-008 SHALL have port out_ready, input, 1 bit: sink accepts the block when out_valid and out_ready are both high.
REQ-009 SHALL have port collecting, output, 1 bit: high while a block is partially assembled.
REQ-010 SHALL have port overflow, output, 1 bit: sticky error flag for dropped beats.

Function
REQ-011 SHALL implement states IDLE, COLLECT and HOLD, with a 3-bit beat counter.
REQ-012 In IDLE, a done beat SHALL be stored in bits [127:112] of both share registers, set the counter to 1 and move to COLLECT.
REQ-013 In COLLECT, beat n (0-based) SHALL be stored in bits [127-16n : 112-16n], with the same slice used for both shares.
REQ-014 Cycles with done low SHALL be allowed inside a block (gaps); the counter SHALL advance only on done.
REQ-015 Capture of beat 7 SHALL move to HOLD, asserting out_valid on the next cycle; latency from last beat to out_valid is 1 cycle.
REQ-016 In HOLD, out_share0, out_share1 and out_valid SHALL stay stable until the handshake completes.
REQ-017 In HOLD, a handshake with done low SHALL return to IDLE.
REQ-018 In HOLD, a handshake with done high SHALL capture that beat as beat 0 of the next block and enter COLLECT, with no bubble.
REQ-019 In HOLD with no handshake, done high SHALL drop the beat, leave the held data unchanged and set overflow.
REQ-020 overflow SHALL clear only on reset.
REQ-021 collecting SHALL be high exactly in the COLLECT state.
REQ-022 The shares SHALL never be combined (XORed) inside the block except as specified in REQ-026.
REQ-023 The share-0 and share-1 datapaths SHALL be separate registers.

Reset
REQ-024 rst high at a clock edge SHALL force state IDLE, counter 0, out_share0 = 0, out_share1 = 0, out_valid = 0 and overflow = 0, overriding any concurrent done or handshake.
REQ-025 A reset asserted mid-COLLECT or mid-HOLD SHALL discard the partial or held block, with no output produced for it.

Configuration
REQ-026 With macro AES_UNMASKED_OUT_EN defined, the block SHALL add output out_cipher, 128 bits, registered, equal to out_share0 XOR out_share1, valid under the same out_valid, and reset to 0.
REQ-027 Without AES_UNMASKED_OUT_EN, out_cipher SHALL be absent and no XOR of the shares SHALL be synthesized.

Verification
REQ-028 8 consecutive done beats, share0 = 0x69c4,0xe0d8,...,0xc55a (FIPS-197 C.1 ciphertext) and share1 = 0 -> out_share0 = 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid high 1 cycle after beat 7.
REQ-029 Random share1 mask M, share0 = C XOR M per beat, gaps of 0-3 cycles between beats -> out_share0 XOR out_share1 = C; with AES_UNMASKED_OUT_EN, out_cipher = C.
REQ-030 out_ready held low, block held, then 1 extra done beat -> overflow = 1 and held data unchanged; after out_ready, a new block assembles correctly and overflow stays 1.
REQ-031 out_ready high in the same cycle as the first beat of the next block -> both blocks delivered, second intact, 16 back-to-back beats produce 2 blocks.
REQ-032 rst pulsed after 4 beats -> out_valid stays 0 and collecting = 0; the next 8 beats produce exactly one correct block.
